mem_arbiter: RTL and testbench

- Parametrised successor to the two-cache memory front end: arbitrates N_CH cache requesters (I-cache, D-cache, future extra ports) onto one pipelined main memory.
- Runs a complete block-fill sequence for read misses and single-word write-through for stores.
- Returns fill words tagged with their index inside the block.
- Sits between the caches and the main memory model; replaces the ad-hoc miss-address mux and stall logic.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_arb.sv | 38 +++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the multi-channel memory arbiter: FSM encoding,
// arbitration mode selectors and a constant-width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  // Ceiling log2 for elaboration-time widths; values up to 2^30 are enough here.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb.sv
// Combinational request picker: fixed priority from index 0, or round robin
// starting at the supplied pointer and wrapping.
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int RR   = RR_FIXED,
  parameter int IW   = 1
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [N_CH-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  int          w_start;
  logic [IW-1:0] w_cand;

  // The first requester found while scanning from the start index wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    w_start = (RR == RR_ROUND) ? int'(i_ptr) : 0;
    for (int k = 0; k < N_CH; k++) begin
      w_cand = IW'((w_start + k) % N_CH);
      if (i_en && !o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel cache front end: arbitrates block fills and write-through
// stores from N_CH requesters onto one pipelined main memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int N_CH        = 2,
  parameter  int AW          = 16,
  parameter  int DW          = 16,
  parameter  int BLOCK_WORDS = 8,
  parameter  int RR          = RR_FIXED,
  localparam int IDXW        = clog2(BLOCK_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH-1:0]      wr,
  input  logic [N_CH*AW-1:0]   addr,
  input  logic [N_CH*DW-1:0]   wdata,
  output logic [N_CH-1:0]      grant,
  output logic [N_CH-1:0]      fill_valid,
  output logic [DW-1:0]        fill_data,
  output logic [IDXW-1:0]      fill_idx,
  output logic [N_CH-1:0]      done,
  output logic                 busy,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_valid
);

  localparam int CW = IDXW + 1;
  localparam int IW = (N_CH > 1) ? clog2(N_CH) : 1;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] N_WORDS    = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST_IDX   = CW'(BLOCK_WORDS - 1);

  state_t          r_state;
  logic [N_CH-1:0] r_grant;
  logic [N_CH-1:0] r_done;
  logic [CW-1:0]   r_issueCnt;
  logic [CW-1:0]   r_retCnt;
  logic [AW-1:0]   r_base;
  logic [AW-1:0]   r_memAddr;
  logic [DW-1:0]   r_memWdata;
  logic            r_memEn;
  logic            r_memWr;
  logic [IW-1:0]   r_ptr;

  logic [N_CH-1:0] w_winGnt;
  logic [IW-1:0]   w_winIdx;
  logic            w_winValid;
  logic            w_arbEn;
  logic [AW-1:0]   w_winAddr;
  logic [DW-1:0]   w_winWdata;
  logic [IW-1:0]   w_nextPtr;
  logic            w_fillBeat;

  assign w_arbEn    = (r_state == IDLE);
  assign w_winAddr  = addr[w_winIdx*AW +: AW];
  assign w_winWdata = wdata[w_winIdx*DW +: DW];
  assign w_nextPtr  = (w_winIdx == IW'(N_CH - 1)) ? '0 : w_winIdx + IW'(1);
  assign w_fillBeat = (r_state == FILL) && mem_valid;

  rr_arbiter #(
    .N_CH (N_CH),
    .RR   (RR),
    .IW   (IW)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_en    (w_arbEn),
    .o_gnt   (w_winGnt),
    .o_idx   (w_winIdx),
    .o_valid (w_winValid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_done     <= '0;
      r_issueCnt <= '0;
      r_retCnt   <= '0;
      r_base     <= '0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_memEn    <= 1'b0;
      r_memWr    <= 1'b0;
      r_ptr      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= '0;
          if (w_winValid) begin
            r_grant <= w_winGnt;
            r_ptr   <= w_nextPtr;
            r_memEn <= 1'b1;
            if (wr[w_winIdx]) begin
              r_state    <= WRITE;
              r_memWr    <= 1'b1;
              r_memAddr  <= w_winAddr;
              r_memWdata <= w_winWdata;
            end else begin
              // Word 0 goes out immediately, so the issue counter starts at 1.
              r_state    <= FILL;
              r_memWr    <= 1'b0;
              r_base     <= w_winAddr & ALIGN_MASK;
              r_memAddr  <= w_winAddr & ALIGN_MASK;
              r_issueCnt <= CW'(1);
            end
          end
        end
        FILL: begin
          if (r_issueCnt < N_WORDS) begin
            r_memEn    <= 1'b1;
            r_memAddr  <= r_base + AW'(r_issueCnt);
            r_issueCnt <= r_issueCnt + CW'(1);
          end else begin
            r_memEn   <= 1'b0;
            r_memAddr <= '0;
          end
          if (mem_valid) begin
            r_retCnt <= r_retCnt + CW'(1);
            if (r_retCnt == LAST_IDX) begin
              r_state <= DONE;
              r_done  <= r_grant;
              r_memEn <= 1'b0;
            end
          end
        end
        WRITE: begin
          r_state    <= DONE;
          r_done     <= r_grant;
          r_memEn    <= 1'b0;
          r_memWr    <= 1'b0;
          r_memAddr  <= '0;
          r_memWdata <= '0;
        end
        DONE: begin
          r_state    <= IDLE;
          r_done     <= '0;
          r_grant    <= '0;
          r_issueCnt <= '0;
          r_retCnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign busy       = (r_state != IDLE);
  assign mem_en     = r_memEn;
  assign mem_wr     = r_memWr;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;
  assign fill_valid = w_fillBeat ? r_grant : '0;
  assign fill_data  = w_fillBeat ? mem_rdata : '0;
  assign fill_idx   = r_retCnt[IDXW-1:0];

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter side by side against a
// latency-L memory and compares every operation with a transaction-level model.
module tb_mem_arbiter;

  localparam int N_CH   = 2;
  localparam int BW     = 8;
  localparam int L      = 4;
  localparam int BUDGET = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeClr;
  logic        stray;
  logic [1:0]  reqV;
  logic [1:0]  wrV;
  logic [15:0] addrV [2];
  logic [15:0] wdataV [2];
  logic [31:0] addrBus;
  logic [31:0] wdataBus;
  logic [15:0] seed;
  int          rrPtr;
  int          nChecks;
  int          nErrors;

  logic [1:0]  grantO [2];
  logic [1:0]  fillValidO [2];
  logic [15:0] fillDataO [2];
  logic [2:0]  fillIdxO [2];
  logic [1:0]  doneO [2];
  logic        busyO [2];
  logic        memEnO [2];
  logic        memWrO [2];
  logic [15:0] memAddrO [2];
  logic [15:0] memWdataO [2];
  logic [15:0] memRdataI [2];
  logic        memValidI [2];

  logic [L-1:0] vPipe [2];
  logic [15:0]  aPipe [2][L];

  always #5 clk = ~clk;

  assign addrBus  = {addrV[1], addrV[0]};
  assign wdataBus = {wdataV[1], wdataV[0]};

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return (a * 16'h9E37) ^ seed;
  endfunction

  // Read-only memory model: every read returns memWord(addr) exactly L cycles later.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pipeClr) vPipe[i] <= '0;
      else         vPipe[i] <= {vPipe[i][L-2:0], memEnO[i] & ~memWrO[i]};
      aPipe[i][0] <= memAddrO[i];
      for (int j = 1; j < L; j++) aPipe[i][j] <= aPipe[i][j-1];
    end
  end

  assign memValidI[0] = vPipe[0][L-1] | stray;
  assign memValidI[1] = vPipe[1][L-1] | stray;
  assign memRdataI[0] = memWord(aPipe[0][L-1]);
  assign memRdataI[1] = memWord(aPipe[1][L-1]);

  mem_arbiter #(.N_CH(2), .AW(16), .DW(16), .BLOCK_WORDS(8), .RR(0)) dutFixed (
    .clk(clk), .rst(rst), .req(reqV), .wr(wrV), .addr(addrBus), .wdata(wdataBus),
    .grant(grantO[0]), .fill_valid(fillValidO[0]), .fill_data(fillDataO[0]),
    .fill_idx(fillIdxO[0]), .done(doneO[0]), .busy(busyO[0]), .mem_en(memEnO[0]),
    .mem_wr(memWrO[0]), .mem_addr(memAddrO[0]), .mem_wdata(memWdataO[0]),
    .mem_rdata(memRdataI[0]), .mem_valid(memValidI[0])
  );

  mem_arbiter #(.N_CH(2), .AW(16), .DW(16), .BLOCK_WORDS(8), .RR(1)) dutRound (
    .clk(clk), .rst(rst), .req(reqV), .wr(wrV), .addr(addrBus), .wdata(wdataBus),
    .grant(grantO[1]), .fill_valid(fillValidO[1]), .fill_data(fillDataO[1]),
    .fill_idx(fillIdxO[1]), .done(doneO[1]), .busy(busyO[1]), .mem_en(memEnO[1]),
    .mem_wr(memWrO[1]), .mem_addr(memAddrO[1]), .mem_wdata(memWdataO[1]),
    .mem_rdata(memRdataI[1]), .mem_valid(memValidI[1])
  );

  function automatic int lowestReq(input logic [1:0] r);
    for (int c = 0; c < N_CH; c++) if (r[c]) return c;
    return 0;
  endfunction

  function automatic int roundReq(input logic [1:0] r, input int p);
    int c;
    for (int k = 0; k < N_CH; k++) begin
      c = (p + k) % N_CH;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input int inst, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag, "/grant"}, i, 32'(grantO[i]), 0);
      checkOutput({tag, "/fill_valid"}, i, 32'(fillValidO[i]), 0);
      checkOutput({tag, "/fill_data"}, i, 32'(fillDataO[i]), 0);
      checkOutput({tag, "/fill_idx"}, i, 32'(fillIdxO[i]), 0);
      checkOutput({tag, "/done"}, i, 32'(doneO[i]), 0);
      checkOutput({tag, "/busy"}, i, 32'(busyO[i]), 0);
      checkOutput({tag, "/mem_en"}, i, 32'(memEnO[i]), 0);
      checkOutput({tag, "/mem_wr"}, i, 32'(memWrO[i]), 0);
      checkOutput({tag, "/mem_addr"}, i, 32'(memAddrO[i]), 0);
      checkOutput({tag, "/mem_wdata"}, i, 32'(memWdataO[i]), 0);
    end
  endtask

  // Call at a negedge with both arbiters idle and reqV set; the next posedge
  // is the arbitration edge. Window k is the k-th negedge after that edge.
  task automatic applyStimulus(input string tag, input logic [1:0] raiseMask,
                               input int dropK, input bit keepReq);
    int          expCh [2];
    bit          expWr [2];
    logic [15:0] expA [2];
    logic [15:0] expD [2];
    logic [15:0] base;
    logic [15:0] issA [2][16];
    logic [15:0] issD [2][16];
    logic        issW [2][16];
    int          issK [2][16];
    int          nIss [2];
    logic [15:0] retD [2][16];
    logic [2:0]  retI [2][16];
    int          nRet [2];
    int          badFv [2];
    int          doneK [2];
    int          nDone [2];
    int          idleK [2];
    logic [1:0]  doneVal [2];
    logic [1:0]  grantDone [2];
    logic [1:0]  grantFirst [2];
    logic        enFirst [2];
    logic [1:0]  owner;
    bit          clearedReq;

    expCh[0] = lowestReq(reqV);
    expCh[1] = roundReq(reqV, rrPtr);
    rrPtr    = (expCh[1] + 1) % N_CH;
    for (int i = 0; i < 2; i++) begin
      expWr[i]      = wrV[expCh[i][0]];
      expA[i]       = addrV[expCh[i][0]];
      expD[i]       = wdataV[expCh[i][0]];
      nIss[i]       = 0;
      nRet[i]       = 0;
      badFv[i]      = 0;
      doneK[i]      = 0;
      nDone[i]      = 0;
      idleK[i]      = 0;
      doneVal[i]    = '0;
      grantDone[i]  = '0;
      grantFirst[i] = '0;
      enFirst[i]    = 1'b0;
    end
    clearedReq = 1'b0;

    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        owner = 2'(1 << expCh[i]);
        if (k == 1) begin
          grantFirst[i] = grantO[i];
          enFirst[i]    = memEnO[i];
        end
        if (memEnO[i] && nIss[i] < 16) begin
          issA[i][nIss[i]] = memAddrO[i];
          issD[i][nIss[i]] = memWdataO[i];
          issW[i][nIss[i]] = memWrO[i];
          issK[i][nIss[i]] = k;
          nIss[i]++;
        end
        if (fillValidO[i] != 2'b00) begin
          if (fillValidO[i] !== owner) badFv[i]++;
          if (nRet[i] < 16) begin
            retD[i][nRet[i]] = fillDataO[i];
            retI[i][nRet[i]] = fillIdxO[i];
            nRet[i]++;
          end
        end
        if (doneO[i] != 2'b00) begin
          nDone[i]++;
          if (doneK[i] == 0) begin
            doneK[i]     = k;
            doneVal[i]   = doneO[i];
            grantDone[i] = grantO[i];
          end
        end
        if (doneK[i] != 0 && k > doneK[i] && idleK[i] == 0 && !busyO[i]) idleK[i] = k;
      end
      if (k == 1) reqV = reqV | raiseMask;
      if (k == dropK) reqV[expCh[0][0]] = 1'b0;
      if (!keepReq && !clearedReq && (doneK[0] != 0 || doneK[1] != 0)) begin
        reqV       = '0;
        clearedReq = 1'b1;
      end
      if (idleK[0] != 0 && idleK[1] != 0) break;
    end

    for (int i = 0; i < 2; i++) begin
      owner = 2'(1 << expCh[i]);
      checkOutput({tag, "/grant"}, i, 32'(grantFirst[i]), 32'(owner));
      checkOutput({tag, "/firstEn"}, i, 32'(enFirst[i]), 1);
      if (expWr[i]) begin
        checkOutput({tag, "/issueCount"}, i, nIss[i], 1);
        if (nIss[i] > 0) begin
          checkOutput({tag, "/wrQual"}, i, 32'(issW[i][0]), 1);
          checkOutput({tag, "/wrAddr"}, i, 32'(issA[i][0]), 32'(expA[i]));
          checkOutput({tag, "/wrData"}, i, 32'(issD[i][0]), 32'(expD[i]));
          checkOutput({tag, "/wrCycle"}, i, issK[i][0], 1);
        end
        checkOutput({tag, "/fillCount"}, i, nRet[i], 0);
        checkOutput({tag, "/doneCycle"}, i, doneK[i], 2);
      end else begin
        base = expA[i] & ~16'(BW - 1);
        checkOutput({tag, "/issueCount"}, i, nIss[i], BW);
        for (int j = 0; j < BW && j < nIss[i]; j++) begin
          checkOutput({tag, "/issueAddr"}, i, 32'(issA[i][j]), 32'(16'(base + j)));
          checkOutput({tag, "/issueWr"}, i, 32'(issW[i][j]), 0);
          checkOutput({tag, "/issueCycle"}, i, issK[i][j], j + 1);
        end
        checkOutput({tag, "/fillCount"}, i, nRet[i], BW);
        for (int j = 0; j < BW && j < nRet[i]; j++) begin
          checkOutput({tag, "/fillIdx"}, i, 32'(retI[i][j]), j);
          checkOutput({tag, "/fillData"}, i, 32'(retD[i][j]), 32'(memWord(16'(base + j))));
        end
        checkOutput({tag, "/doneCycle"}, i, doneK[i], L + BW + 1);
      end
      checkOutput({tag, "/fillOwner"}, i, badFv[i], 0);
      checkOutput({tag, "/donePulses"}, i, nDone[i], 1);
      checkOutput({tag, "/doneOwner"}, i, 32'(doneVal[i]), 32'(owner));
      checkOutput({tag, "/grantAtDone"}, i, 32'(grantDone[i]), 32'(owner));
      checkOutput({tag, "/idleCycle"}, i, idleK[i], doneK[i] + 1);
    end
  endtask

  initial begin
    int hit;
    int sawBad;
    nChecks = 0;
    nErrors = 0;
    seed    = 16'($urandom);
    rrPtr   = 0;
    rst     = 1'b0;
    pipeClr = 1'b1;
    stray   = 1'b0;
    reqV    = 2'b11;
    wrV     = 2'b00;
    addrV[0] = '0; addrV[1] = '0;
    wdataV[0] = '0; wdataV[1] = '0;
    $display("[TB] mem_arbiter bench start, seed=%0h", seed);

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    pipeClr = 1'b0;
    rst     = 1'b1;
    reqV    = 2'b00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) checkOutput("idleBusy", i, 32'(busyO[i]), 0);

    addrV[1] = 16'h0123;
    reqV     = 2'b10;
    applyStimulus("fill", 2'b00, 0, 1'b0);

    addrV[1]  = 16'h0042;
    wdataV[1] = 16'hBEEF;
    wrV       = 2'b10;
    reqV      = 2'b10;
    applyStimulus("write", 2'b00, 0, 1'b0);

    wrV      = 2'b00;
    addrV[0] = 16'($urandom);
    addrV[1] = 16'($urandom);
    reqV     = 2'b11;
    applyStimulus("arb1", 2'b00, 0, 1'b1);
    applyStimulus("arb2", 2'b00, 0, 1'b1);
    applyStimulus("arb3", 2'b00, 0, 1'b0);

    // Reset in the middle of a fill, then make sure in-flight and stray data are dropped.
    addrV[0] = 16'($urandom);
    reqV     = 2'b01;
    hit      = 0;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (fillValidO[0] != 2'b00 && fillIdxO[0] == 3'd3) begin
        hit = 1;
        break;
      end
    end
    checkOutput("abortReach", 0, hit, 1);
    rst   = 1'b0;
    reqV  = 2'b00;
    rrPtr = 0;
    #1;
    checkAllZero("abortReset");
    @(negedge clk);
    rst    = 1'b1;
    sawBad = 0;
    repeat (L + 4) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (fillValidO[i] != 2'b00 || doneO[i] != 2'b00 || busyO[i]) sawBad++;
    end
    checkOutput("abortQuiet", 0, sawBad, 0);
    stray = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) checkOutput("strayValid", i, 32'(fillValidO[i]), 0);
    stray = 1'b0;
    @(negedge clk);
    addrV[0] = 16'($urandom);
    reqV     = 2'b01;
    applyStimulus("afterAbort", 2'b00, 0, 1'b0);

    addrV[0] = 16'($urandom);
    addrV[1] = 16'($urandom);
    reqV     = 2'b01;
    applyStimulus("reqDrop", 2'b10, 6, 1'b1);
    applyStimulus("pending", 2'b00, 0, 1'b0);

    repeat (8) begin
      reqV      = 2'($urandom_range(1, 3));
      wrV       = 2'($urandom_range(0, 3));
      addrV[0]  = 16'($urandom);
      addrV[1]  = 16'($urandom);
      wdataV[0] = 16'($urandom);
      wdataV[1] = 16'($urandom);
      applyStimulus("random", 2'b00, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
